fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Tracks the destination register of every in-flight instruction in the EX, MEM and WB stages. For the instruction leaving decode it produces the registered operand-forwarding selects `fua_cs_1`/`fua_cs_2` consumed by the EX-stage operand mux. It also detects load-use hazards, stalling decode and inserting one bubble into EX. It sits between the decode stage and the EX stage, alongside the ID/EX pipeline register.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register-index width.
- `CNT_W`, default 32: statistics counter width (only used under `FWD_STATS_EN`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  decode holds a real instruction.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source register indices.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the instruction reads that source.
- `id_rd`  in  REG_ADDR_W  destination register index.
- `id_reg_write`  in  1  the instruction writes `id_rd`.
- `id_mem_read`  in  1  the instruction is a load.
- `flush`  in  1  a taken branch or jump resolved in EX; kills the instruction in decode.
- `fua_cs_1`, `fua_cs_2`  out  2  forwarding selects for the EX instruction. 00 = register file, 01 = MEM-stage result, 10 = WB-stage data, 11 never driven.
- `stall`  out  1  hold PC and the IF/ID register this cycle.
- `ex_bubble`  out  1  the EX stage holds a bubble this cycle (registered).
- `stat_stalls`, `stat_fwds`  out  CNT_W  only when `FWD_STATS_EN` is defined.

## Operation
- Internal stage tags `ex_t`, `mem_t`, `wb_t`, each holding {valid, rd, reg_write, mem_read}. All of them shift one stage on every clock edge.
- A match between source s and stage tag T requires all of: T.valid, T.reg_write, T.rd == s, s != 0, and the matching `id_uses_rsN` asserted.
- `issue` = `id_valid` & !`stall` & !`flush`.
- Load-use hazard (combinational): `id_valid` & !`flush` & `ex_t.mem_read` & a match with `ex_t` on either source. While the hazard holds, `stall` = 1.
- On each clock edge:
  - `wb_t` <= `mem_t`.
  - `mem_t` <= `ex_t`.
  - `ex_t` <= the decode fields if `issue`, otherwise invalid (bubble).
  - `fua_cs_N` <= computed from the current `ex_t`/`mem_t` when `issue`, otherwise 00.
- Select rule for source N:
  - match with `ex_t` (will be in MEM next cycle) -> 01;
  - else match with `mem_t` (will be in WB next cycle) -> 10;
  - else 00.
  - The newest producer wins.
- A match with `wb_t` needs no forward, because the register file is write-before-read.
- After a one-cycle load-use stall, the load sits in `mem_t`, so the dependent instruction gets 10.
- `flush` overrides `stall`: `stall` = 0 and a bubble enters EX.
- `ex_bubble` <= !`issue`.

## Timing
- `stall` is combinational and is valid in the same cycle as the decode inputs.
- `fua_cs_1`/`fua_cs_2`/`ex_bubble` are registered, valid for the whole cycle the instruction occupies EX, with latency 1 from issue.
- Load-use costs exactly one stall cycle. No hazard causes a stall of two or more cycles.
- Reset (async):
  - all tag valids = 0;
  - `fua_cs_1` = `fua_cs_2` = 00;
  - `ex_bubble` = 1;
  - counters = 0;
  - `stall` = 0, since all tags are invalid.
- Reset asserted mid-stall discards the stall. After release, the held instruction is re-evaluated from empty tags.

## Configuration
- `FWD_STATS_EN` defined:
  - `stat_stalls` increments on every cycle with `stall` = 1.
  - `stat_fwds` increments on every issue with either select != 00.
  - Both counters saturate at all-ones and reset to 0.
- `FWD_STATS_EN` undefined: the ports and counters are absent, and the rest of the behaviour is identical.

## Structure
- `riscv_pkg` holds:
  - `fwd_sel_t` with constants `FWD_RF` = 2'b00, `FWD_MEM` = 2'b01, `FWD_WB` = 2'b10;
  - `stage_tag_t`, the struct {valid, rd, reg_write, mem_read}.
- One sub-module, `fwd_select`: a combinational select for one source (inputs: source index, use flag, `ex_t`, `mem_t`; output: `fwd_sel_t`). It is instantiated twice.

## Test plan
- `addi x5` issued, then `add x6,x5,x5` the next cycle -> `fua_cs_1` = `fua_cs_2` = 01 in the EX cycle of the `add`, `stall` = 0.
- `addi x5`, an unrelated instruction, then `sub x7,x5,x1` -> `fua_cs_1` = 10, `fua_cs_2` = 00.
- `addi x5,x0,1`, `addi x5,x0,2`, then `add x8,x5,x0` -> `fua_cs_1` = 01 (newest producer wins).
- `lw x9`, then `add x10,x9,x2` -> `stall` high for exactly 1 cycle, `ex_bubble` = 1 for 1 cycle, then `fua_cs_1` = 10 for the `add`.
- Writer with `rd` = x0, then a reader of x0 -> selects 00. `lw x9` with `flush` asserted on the dependent instruction -> `stall` = 0, bubble inserted.
- With `FWD_STATS_EN`: preload the counters near all-ones and force stalls -> `stat_stalls` holds at all-ones. Assert `rst` mid-stall -> `stall` drops asynchronously.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types for the forwarding/hazard unit: select codes and stage tags
package riscv_pkg;

  // Stage tags carry rd at this fixed width; REG_ADDR_W must not exceed it.
  localparam int RD_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_tag_t;

endpackage

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - forwarding select for one source operand; the newest producer wins
module fwd_select
  import riscv_pkg::*;
(
  input  logic [RD_MAX_W-1:0] i_src,
  input  logic                i_use,
  input  stage_tag_t          i_ex_t,
  input  stage_tag_t          i_mem_t,
  output fwd_sel_t            o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused;

  assign w_ex_hit  = i_use && (i_src != '0) && i_ex_t.valid && i_ex_t.reg_write
                     && (i_ex_t.rd == i_src);
  assign w_mem_hit = i_use && (i_src != '0) && i_mem_t.valid && i_mem_t.reg_write
                     && (i_mem_t.rd == i_src);
  assign w_unused  = i_ex_t.mem_read ^ i_mem_t.mem_read;

  always_comb begin
    o_sel = FWD_RF;
    if (w_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX/MEM/WB destination tracking, registered forwarding selects, load-use stall
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fua_cs_1,
  output logic [1:0]            fua_cs_2,
  output logic                  stall,
  output logic                  ex_bubble
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stat_stalls,
  output logic [CNT_W-1:0]      stat_fwds
`endif
);

  stage_tag_t r_ex_t;
  stage_tag_t r_mem_t;
  stage_tag_t r_wb_t;
  fwd_sel_t   r_cs_1;
  fwd_sel_t   r_cs_2;
  logic       r_ex_bubble;

  fwd_sel_t   w_sel_1;
  fwd_sel_t   w_sel_2;
  logic       w_hazard;
  logic       w_issue;
  stage_tag_t w_id_t;
  logic       w_unused_wb;

  fwd_select u_sel_1 (
    .i_src   (RD_MAX_W'(id_rs1)),
    .i_use   (id_uses_rs1),
    .i_ex_t  (r_ex_t),
    .i_mem_t (r_mem_t),
    .o_sel   (w_sel_1)
  );

  fwd_select u_sel_2 (
    .i_src   (RD_MAX_W'(id_rs2)),
    .i_use   (id_uses_rs2),
    .i_ex_t  (r_ex_t),
    .i_mem_t (r_mem_t),
    .o_sel   (w_sel_2)
  );

  // A FWD_MEM select means the EX-stage producer matched; if it is a load its data is not ready yet.
  assign w_hazard = id_valid && !flush && r_ex_t.mem_read
                    && ((w_sel_1 == FWD_MEM) || (w_sel_2 == FWD_MEM));
  assign w_issue  = id_valid && !w_hazard && !flush;

  assign w_id_t.valid     = 1'b1;
  assign w_id_t.rd        = RD_MAX_W'(id_rd);
  assign w_id_t.reg_write = id_reg_write;
  assign w_id_t.mem_read  = id_mem_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_t      <= '0;
      r_mem_t     <= '0;
      r_wb_t      <= '0;
      r_cs_1      <= FWD_RF;
      r_cs_2      <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end else begin
      r_ex_t      <= w_issue ? w_id_t : '0;
      r_mem_t     <= r_ex_t;
      r_wb_t      <= r_mem_t;
      r_cs_1      <= w_issue ? w_sel_1 : FWD_RF;
      r_cs_2      <= w_issue ? w_sel_2 : FWD_RF;
      r_ex_bubble <= !w_issue;
    end
  end

  // The WB tag is kept for pipeline visibility only; write-before-read makes it need no forward.
  assign w_unused_wb = ^r_wb_t;

  assign fua_cs_1  = r_cs_1;
  assign fua_cs_2  = r_cs_2;
  assign stall     = w_hazard;
  assign ex_bubble = r_ex_bubble;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] r_stat_stalls;
  logic [CNT_W-1:0] r_stat_fwds;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_stalls <= '0;
      r_stat_fwds   <= '0;
    end else begin
      if (w_hazard && (r_stat_stalls != '1)) begin
        r_stat_stalls <= r_stat_stalls + 1'b1;
      end
      if (w_issue && ((w_sel_1 != FWD_RF) || (w_sel_2 != FWD_RF))
          && (r_stat_fwds != '1)) begin
        r_stat_fwds <= r_stat_fwds + 1'b1;
      end
    end
  end

  assign stat_stalls = r_stat_stalls;
  assign stat_fwds   = r_stat_fwds;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - directed self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  localparam int RW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0;
  logic [RW-1:0] id_rs2 = '0;
  logic          id_uses_rs1 = 1'b0;
  logic          id_uses_rs2 = 1'b0;
  logic [RW-1:0] id_rd = '0;
  logic          id_reg_write = 1'b0;
  logic          id_mem_read = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    fua_cs_1;
  logic [1:0]    fua_cs_2;
  logic          stall;
  logic          ex_bubble;
`ifdef FWD_STATS_EN
  logic [CW-1:0] stat_stalls;
  logic [CW-1:0] stat_fwds;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fwd_hazard_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .fua_cs_1     (fua_cs_1),
    .fua_cs_2     (fua_cs_2),
    .stall        (stall),
    .ex_bubble    (ex_bubble)
`ifdef FWD_STATS_EN
    ,
    .stat_stalls  (stat_stalls),
    .stat_fwds    (stat_fwds)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2, input logic [RW-1:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    #12;
    chk("reset_cs1", 32'(fua_cs_1), 32'h0);
    chk("reset_cs2", 32'(fua_cs_2), 32'h0);
    chk("reset_bubble", 32'(ex_bubble), 32'h1);
    chk("reset_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    tick();

    // addi x5 ; add x6,x5,x5
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0); #3;
    chk("t1_stall", 32'(stall), 32'h0);
    tick();
    chk("t1_cs1", 32'(fua_cs_1), 32'h1);
    chk("t1_cs2", 32'(fua_cs_2), 32'h1);
    chk("t1_bubble", 32'(ex_bubble), 32'h0);
    drain();

    // addi x5 ; addi x11 ; sub x7,x5,x1
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 0, 5'd11, 1, 0, 0); tick();
    drive(1, 5'd5, 1, 5'd1, 1, 5'd7, 1, 0, 0); tick();
    chk("t2_cs1", 32'(fua_cs_1), 32'h2);
    chk("t2_cs2", 32'(fua_cs_2), 32'h0);
    drain();

    // addi x5,x0,1 ; addi x5,x0,2 ; add x8,x5,x0
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 5'd5, 1, 5'd0, 1, 5'd8, 1, 0, 0); tick();
    chk("t3_cs1", 32'(fua_cs_1), 32'h1);
    chk("t3_cs2", 32'(fua_cs_2), 32'h0);
    drain();

    // lw x9 ; add x10,x9,x2
    drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1, 0); tick();
    drive(1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 0); #3;
    chk("t4_stall_on", 32'(stall), 32'h1);
    tick();
    chk("t4_bubble_on", 32'(ex_bubble), 32'h1);
    chk("t4_bubble_cs1", 32'(fua_cs_1), 32'h0);
    #3;
    chk("t4_stall_off", 32'(stall), 32'h0);
    tick();
    chk("t4_cs1", 32'(fua_cs_1), 32'h2);
    chk("t4_cs2", 32'(fua_cs_2), 32'h0);
    chk("t4_bubble_off", 32'(ex_bubble), 32'h0);
    drain();

    // writer x0 ; reader x0
    drive(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0); #3;
    chk("t5_stall", 32'(stall), 32'h0);
    tick();
    chk("t5_cs1", 32'(fua_cs_1), 32'h0);
    chk("t5_cs2", 32'(fua_cs_2), 32'h0);
    drain();

    // writer x5 ; reader names x5 but does not use it
    drive(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0); tick();
    drive(1, 5'd5, 0, 5'd5, 0, 5'd13, 1, 0, 0); tick();
    chk("t5b_cs1", 32'(fua_cs_1), 32'h0);
    chk("t5b_cs2", 32'(fua_cs_2), 32'h0);
    drain();

    // lw x9 ; dependent instruction flushed
    drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1, 0); tick();
    drive(1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 1); #3;
    chk("t6_stall", 32'(stall), 32'h0);
    tick();
    chk("t6_bubble", 32'(ex_bubble), 32'h1);
    chk("t6_cs1", 32'(fua_cs_1), 32'h0);
    drain();

    // reset asserted mid-stall
    drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1, 0); tick();
    drive(1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 0); #3;
    chk("t7_stall_on", 32'(stall), 32'h1);
    rst = 1'b1; #1;
    chk("t7_stall_rst", 32'(stall), 32'h0);
    chk("t7_bubble_rst", 32'(ex_bubble), 32'h1);
    #1 rst = 1'b0; #1;
    chk("t7_stall_rel", 32'(stall), 32'h0);
    @(posedge clk); #1;
    chk("t7_bubble_iss", 32'(ex_bubble), 32'h0);
    chk("t7_cs1", 32'(fua_cs_1), 32'h0);

`ifdef FWD_STATS_EN
    chk("st_stalls_zero", 32'(stat_stalls), 32'h0);
    chk("st_fwds_zero", 32'(stat_fwds), 32'h0);
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'd0, 1, 5'd0, 0, 5'd9, 1, 1, 0); tick();
      drive(1, 5'd9, 1, 5'd2, 1, 5'd10, 1, 0, 0); tick();
      tick();
    end
    nop(); tick();
    chk("st_stalls_sat", 32'(stat_stalls), 32'h7);
    chk("st_fwds_sat", 32'(stat_fwds), 32'h7);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
